// File: rtl/mac_pkg.sv
// Shared definitions for the MAC job controller slice: FSM state encoding,
// response status codes and the default watchdog length.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  localparam int DEFAULT_TIMEOUT_CYCLES = 100;

endpackage

// File: rtl/mac_edge_det.sv
// Rising-edge detector for level-style "done" signals. The history register
// resets to 1 so a level that is already high when reset releases is not
// mistaken for a fresh rising edge.
module mac_edge_det (
  input  logic clk,
  input  logic srstn,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Track the previous value of the level every cycle
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/mac_job_ctrl.sv
// Initiator side of the MAC start/done handshake. Accepts one job at a time
// from the host, issues a single-cycle start pulse to mac_top, waits for a
// fresh rising edge of processing_done under a watchdog, and returns the job
// tag, status and elapsed WAIT cycles on a valid/ready response channel.
//
// Optional build macro MAC_JOB_CTRL_STATS_EN adds saturating per-status
// completion counters (stat_ok_cnt, stat_to_cnt).
module mac_job_ctrl
  import mac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16,
  parameter int JOB_ID_W       = 4
) (
  input  logic                clk,
  input  logic                srstn,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [JOB_ID_W-1:0] job_id,
  output logic                start_processing,
  input  logic                processing_done,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [JOB_ID_W-1:0] rsp_id,
  output logic [1:0]          rsp_status,
  output logic [CNT_W-1:0]    rsp_cycles,
  output logic                busy
`ifdef MAC_JOB_CTRL_STATS_EN
  ,
  output logic [15:0]         stat_ok_cnt,
  output logic [15:0]         stat_to_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_CYCLES = CNT_W'(TIMEOUT_CYCLES);

  state_t              state;
  logic [CNT_W-1:0]    counter;
  logic [JOB_ID_W-1:0] id_q;
  logic                done_rise;

  mac_edge_det u_done_edge (
    .clk   (clk),
    .srstn (srstn),
    .level (processing_done),
    .rise  (done_rise)
  );

  // Job FSM with registered handshake outputs and the WAIT cycle counter
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state            <= IDLE;
      job_ready        <= 1'b1;
      start_processing <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_status       <= ST_OK;
      rsp_cycles       <= '0;
      busy             <= 1'b0;
      counter          <= '0;
      id_q             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            id_q             <= job_id;
            state            <= START;
            start_processing <= 1'b1;
            job_ready        <= 1'b0;
            busy             <= 1'b1;
          end
        end
        START: begin
          start_processing <= 1'b0;
          counter          <= '0;
          state            <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            rsp_status <= ST_OK;
            rsp_cycles <= counter + CNT_W'(1);
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (counter == LAST_WAIT) begin
            rsp_status <= ST_TIMEOUT;
            rsp_cycles <= TO_CYCLES;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state            <= IDLE;
          job_ready        <= 1'b1;
          start_processing <= 1'b0;
          rsp_valid        <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_JOB_CTRL_STATS_EN
  // Count consumed responses per status, holding at the maximum value
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      stat_ok_cnt <= '0;
      stat_to_cnt <= '0;
    end else if (state == RESP && rsp_ready) begin
      if (rsp_status == ST_OK && stat_ok_cnt != 16'hFFFF) begin
        stat_ok_cnt <= stat_ok_cnt + 16'd1;
      end else if (rsp_status == ST_TIMEOUT && stat_to_cnt != 16'hFFFF) begin
        stat_to_cnt <= stat_to_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
